host_reg_engine: RTL
====================

# host_reg_engine

Register-command engine between the FT2232 receive path and the output multiplexer. Parses host command frames from the received byte stream, performs 32-bit register reads/writes on the shared register bus, and streams a reply frame back to the host as a requester on one output-multiplexer source. Incoming bytes are buffered so none are lost while a command executes or a reply drains.

## Interface
- `FIFO_DEPTH`, 16: input byte FIFO depth; power of two, ≥4.
- `TIMEOUT`, 65535: idle cycles allowed between bytes of one frame before the partial frame is abandoned.

- `clk_i`  in  1  single clock; all logic on its rising edge.
- `nreset_i`  in  1  asynchronous, active-low reset.
- `in_data_i`  in  8  received byte; valid when `in_rdy_i`=1.
- `in_rdy_i`  in  1  one-cycle strobe per received byte; no backpressure.
- `omux_data_o`  out  8  reply byte to the output mux.
- `omux_req_o`  out  1  request to the output mux; high for the whole reply frame.
- `omux_sel_i`  in  1  one-cycle pulse: the current reply byte has been taken.
- `reg_addr_o`  out  16  register address.
- `reg_data_io`  inout  32  register data. Driven only in `WR_SETUP`/`WR_STROBE`; high-Z otherwise.
- `reg_wr_o`  out  1  write strobe.
- `overflow_o`  out  1  sticky: an input byte was dropped.
- `cmd_err_o`  out  1  one-cycle pulse: bad opcode or frame timeout.

## Operation
- Frames are MSB first.
- Read frame: `0x01`, addr_hi, addr_lo.
- Write frame: `0x02`, addr_hi, addr_lo, d3, d2, d1, d0.
- Read reply (7 bytes): `0x01`, addr_hi, addr_lo, d3..d0.
- Write reply (3 bytes): `0x02`, addr_hi, addr_lo.
- FIFO:
  - Push on `in_rdy_i`.
  - Push while full is allowed only if a pop happens in the same cycle. Otherwise the byte is dropped and `overflow_o` is set until reset.
- FSM pops at most one byte per cycle, only in the parse states `IDLE`, `ADDR_HI`, `ADDR_LO`, `DATA`.
- FSM states:
  - `IDLE`: pop opcode. `0x01`/`0x02` go to `ADDR_HI`. Any other value is discarded, pulses `cmd_err_o`, and the FSM stays in `IDLE`.
  - `ADDR_HI` → `ADDR_LO`: one byte each.
  - `ADDR_LO`: read goes to `RD_SETUP`; write goes to `DATA`.
  - `DATA`: 4 bytes, 2-bit counter; then `WR_SETUP`.
  - `RD_SETUP` (address stable) → `RD_SAMPLE`: capture `reg_data_io` at the end of the cycle → `REPLY`.
  - `WR_SETUP`: drive data → `WR_STROBE`: `reg_wr_o`=1 for exactly this cycle → `REPLY`.
  - `REPLY`: `omux_req_o`=1, `omux_data_o` = reply byte[idx].
    - Each `omux_sel_i` pulse advances idx.
    - On the `omux_sel_i` of the last byte, `omux_req_o` is cleared at that same edge, and the FSM goes to `IDLE`.
    - `omux_sel_i` outside `REPLY` is ignored.
- Timeout:
  - Counter clears on every pop and counts in `ADDR_HI`/`ADDR_LO`/`DATA` while the FIFO is empty.
  - When it reaches `TIMEOUT`: partial frame discarded, `cmd_err_o` pulses, FSM goes to `IDLE`.
- `reg_addr_o` holds the last command address until the next `ADDR_LO` pop.
- FIFO keeps accepting input during `RD_*`, `WR_*` and `REPLY`.
- Reset mid-operation:
  - All outputs return to reset values immediately.
  - FIFO emptied; any frame in flight is lost.
  - A pending `reg_wr_o` strobe is killed.

## Timing
- Reset values: `omux_req_o`=0, `omux_data_o`=0x00, `reg_addr_o`=0x0000, `reg_wr_o`=0, `reg_data_io`=Z, `overflow_o`=0, `cmd_err_o`=0.
- A byte strobed in cycle N is poppable in N+1.
- Last command byte strobed in cycle N:
  - Write: `WR_SETUP` at N+2, `reg_wr_o` high at N+3, `omux_req_o` high from N+4.
  - Read: `RD_SETUP` at N+2, sample at the end of N+3, `omux_req_o` high from N+4.
- Register slaves must present read data within one cycle of a stable address.
- `omux_data_o` is stable while `omux_req_o`=1, changing only on the edge following an `omux_sel_i` pulse.
- Minimum reply gap: one cycle in `IDLE` between frames.

## Structure
- Package `host_reg_pkg` holds:
  - opcode constants `OP_READ`=8'h01, `OP_WRITE`=8'h02;
  - FSM state enum;
  - reply lengths 7 and 3.
- Sub-module `byte_fifo` (parameter `DEPTH`; ports push/pop/full/empty/dout), async active-low reset. The parser FSM and reply sequencer stay in `host_reg_engine`.

## Test plan
- Write `02 12 34 DE AD BE EF`:
  - `reg_addr_o`=0x1234 and `reg_data_io`=0xDEADBEEF with a one-cycle `reg_wr_o` at N+3.
  - Reply `02 12 34`, with `omux_req_o` dropping on the third `omux_sel_i`.
- Read `01 00 10` with slave data 0xCAFEF00D:
  - Reply `01 00 10 CA FE F0 0D`.
  - Bus stays high-Z throughout.
- Byte `7F` then read `01 00 01`: one `cmd_err_o` pulse, and the read completes normally.
- 20 back-to-back bytes while stalled in `REPLY` (FIFO_DEPTH=16, `omux_sel_i` withheld): first 16 kept, `overflow_o`=1 and stays set; later frames still parse.
- Send `01 00` then nothing for `TIMEOUT` cycles: `cmd_err_o` pulses, FSM is back in `IDLE`, and the next `01 00 02` reads address 0x0002.
- Assert `nreset_i` low after the second reply byte has been selected: `omux_req_o` goes to 0 asynchronously and the FIFO is empty. After release, a fresh read works.

Source files
------------

// File: rtl/host_reg_pkg.sv
// Shared opcodes, FSM states and reply lengths
// for the host register-command engine.
package host_reg_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam int RD_REPLY_LEN = 7;
  localparam int WR_REPLY_LEN = 3;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA,
    RD_SETUP,
    RD_SAMPLE,
    WR_SETUP,
    WR_STROBE,
    REPLY
  } state_e;

  function automatic logic [2:0] reply_last(
    input logic is_wr
  );
    return is_wr ? 3'(WR_REPLY_LEN - 1)
                 : 3'(RD_REPLY_LEN - 1);
  endfunction

  function automatic logic is_opcode(
    input logic [7:0] b
  );
    return (b == OP_READ) || (b == OP_WRITE);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered pointers; a push while
// full is taken only when a pop frees the slot.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/host_reg_engine.sv
// Host command parser: decodes read/write frames,
// drives the register bus and streams the reply.
module host_reg_engine
  import host_reg_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk_i,
  input  logic        nreset_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_rdy_i,
  output logic [7:0]  omux_data_o,
  output logic        omux_req_o,
  input  logic        omux_sel_i,
  output logic [15:0] reg_addr_o,
  inout  wire  [31:0] reg_data_io,
  output logic        reg_wr_o,
  output logic        overflow_o,
  output logic        cmd_err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q;
  state_e        state_d;
  logic          err_d;
  logic          is_wr_q;
  logic [7:0]    addr_hi_q;
  logic [31:0]   data_q;
  logic [1:0]    cnt_q;
  logic [2:0]    idx_q;
  logic [TW-1:0] to_q;
  logic          tmo;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic          parse_st;
  logic          wait_st;
  logic          pop;
  logic          drop;
  logic          bus_drive;
  logic [7:0]    reply_byte;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .push     (in_rdy_i),
    .pop      (pop),
    .din      (in_data_i),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .dout     (fifo_dout)
  );

  assign wait_st  = state_q inside {ADDR_HI, ADDR_LO, DATA};
  assign parse_st = wait_st || (state_q == IDLE);
  assign pop      = parse_st && !fifo_empty;
  assign drop     = in_rdy_i && fifo_full && !pop;
  assign tmo      = (to_q == TW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          unique case (1'b1)
            is_opcode(fifo_dout): state_d = ADDR_HI;
            default:              err_d   = 1'b1;
          endcase
        end
      end
      ADDR_HI, ADDR_LO, DATA: begin
        if (!fifo_empty) begin
          unique case (state_q)
            ADDR_HI: state_d = ADDR_LO;
            ADDR_LO: state_d = is_wr_q ? DATA : RD_SETUP;
            default: begin
              if (cnt_q == 2'd3) state_d = WR_SETUP;
            end
          endcase
        end else if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      RD_SETUP:  state_d = RD_SAMPLE;
      RD_SAMPLE: state_d = REPLY;
      WR_SETUP:  state_d = WR_STROBE;
      WR_STROBE: state_d = REPLY;
      REPLY: begin
        if (omux_sel_i && idx_q == reply_last(is_wr_q))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= IDLE;
      cmd_err_o  <= 1'b0;
      overflow_o <= 1'b0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      cmd_err_o  <= err_d;
      overflow_o <= overflow_o | drop;
      if (pop || !wait_st) to_q <= '0;
      else if (!tmo)       to_q <= to_q + 1'b1;
    end
  end

  // Address, write data and read data share one datapath
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      is_wr_q    <= 1'b0;
      addr_hi_q  <= '0;
      reg_addr_o <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) is_wr_q <= (fifo_dout == OP_WRITE);
        end
        ADDR_HI: begin
          if (pop) addr_hi_q <= fifo_dout;
        end
        ADDR_LO: begin
          if (pop) begin
            reg_addr_o <= {addr_hi_q, fifo_dout};
            cnt_q      <= '0;
          end
        end
        DATA: begin
          if (pop) begin
            data_q <= {data_q[23:0], fifo_dout};
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        RD_SAMPLE: begin
          data_q <= reg_data_io;
          idx_q  <= '0;
        end
        WR_STROBE: idx_q <= '0;
        REPLY: begin
          if (omux_sel_i) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reply_byte = 8'h00;
    unique case (idx_q)
      3'd0:    reply_byte = is_wr_q ? OP_WRITE : OP_READ;
      3'd1:    reply_byte = reg_addr_o[15:8];
      3'd2:    reply_byte = reg_addr_o[7:0];
      3'd3:    reply_byte = data_q[31:24];
      3'd4:    reply_byte = data_q[23:16];
      3'd5:    reply_byte = data_q[15:8];
      3'd6:    reply_byte = data_q[7:0];
      default: reply_byte = 8'h00;
    endcase
  end

  assign omux_req_o  = (state_q == REPLY);
  assign omux_data_o = omux_req_o ? reply_byte : 8'h00;
  assign reg_wr_o    = (state_q == WR_STROBE);
  assign bus_drive   = (state_q == WR_SETUP) ||
                       (state_q == WR_STROBE);
  assign reg_data_io = bus_drive ? data_q : 'z;

endmodule
